uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/rr_select.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared FSM encoding and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int unsigned OWNER_W              = 3;
    localparam int unsigned DEFAULT_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStart    = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: first set req bit at or after last_grant+1 (wrapping).
module rr_select
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] last_grant,
    output logic               valid,
    output logic [OWNER_W-1:0] index
);

    // Walk offsets from farthest to nearest so the nearest hit is the final assignment.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (req[j] && ((int'(last_grant) + k == j) ||
                               (int'(last_grant) + k == j + int'(NUM_REQ)))) begin
                    valid = 1'b1;
                    index = OWNER_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte requesters.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [OWNER_W-1:0]   owner,
    output logic                 timeout_err
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_e             r_state, w_state_d;
    logic [OWNER_W-1:0] r_last_grant, r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_ack, r_done;
    logic               r_tx_start, r_timeout_err;
    logic [7:0]         r_tx_data;

    logic               w_valid;
    logic [OWNER_W-1:0] w_index;
    logic [7:0]         w_sel_data;
    logic               w_grant, w_start, w_expire, w_finish;

    rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_select (
        .req       (req),
        .last_grant(r_last_grant),
        .valid     (w_valid),
        .index     (w_index)
    );

    always_comb begin
        w_sel_data = 8'h00;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_index == OWNER_W'(i)) begin
                w_sel_data = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:     if (w_valid && !tx_busy) w_state_d = StStart;
            StStart:    w_state_d = StWaitBusy;
            StWaitBusy: begin
                if (tx_busy) begin
                    w_state_d = StWaitDone;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_state_d = StIdle;
                end
            end
            StWaitDone: if (!tx_busy) w_state_d = StIdle;
            default:    w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_grant  = 1'b0;
        w_start  = 1'b0;
        w_expire = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            StIdle:     w_grant = w_valid && !tx_busy;
            StStart:    w_start = 1'b1;
            StWaitBusy: begin
                w_expire = !tx_busy && (r_cnt <= CNT_W'(1));
                w_finish = w_expire;
            end
            StWaitDone: w_finish = !tx_busy;
            default:    ;
        endcase
    end

    // Pulses are registered so ack, tx_start and done each land one edge after their event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack         <= '0;
            r_done        <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_owner       <= '0;
            r_last_grant  <= OWNER_W'(NUM_REQ - 1);
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_done     <= '0;
            r_tx_start <= w_start;
            if (w_grant) begin
                r_ack     <= NUM_REQ'(1) << w_index;
                r_owner   <= w_index;
                r_tx_data <= w_sel_data;
            end
            if (w_start) begin
                r_cnt <= CNT_W'(BUSY_TIMEOUT);
            end else if (r_state == StWaitBusy && !tx_busy) begin
                r_cnt <= w_expire ? '0 : r_cnt - CNT_W'(1);
            end
            if (w_finish) begin
                r_done       <= NUM_REQ'(1) << r_owner;
                r_last_grant <= r_owner;
            end
            if (w_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign ack         = r_ack;
    assign done        = r_done;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign owner       = r_owner;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus directed multi-cycle sequences.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [2:0]  owner;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // UART model: busy rises the edge after tx_start and stays high for busy_len cycles.
    int busy_len   = 0;
    int busy_cnt   = 0;
    bit force_busy = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .BUSY_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .done       (done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .owner      (owner),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (tx_start && busy_len != 0) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign tx_busy = (busy_cnt != 0) || force_busy;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        bit          hold;
        bit          mutate;
        int          blen;
        int          exp_idx;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One complete frame: wait for ack, check grant, then track the frame until done.
    task automatic run_frame(input logic [3:0] r, input logic [31:0] d, input bit hold,
                             input bit mutate, input int blen, input int exp_idx,
                             input logic [7:0] exp_d, input bit exp_to, output int waited);
        bit data_ok;
        bit extra_ack;
        int n;
        req      = r;
        req_data = d;
        busy_len = blen;
        waited   = 0;
        do begin
            step();
            waited++;
        end while (ack == 4'b0 && waited < 20);
        check("ack", 32'(ack), 32'(1) << exp_idx);
        check("owner", 32'(owner), 32'(exp_idx));
        check("tx_data@ack", 32'(tx_data), 32'(exp_d));
        if (!hold) req = 4'b0;
        if (mutate) req_data = d ^ 32'hFFFF_FFFF;
        step();
        check("tx_start", 32'(tx_start), 32'd1);
        data_ok   = 1'b1;
        extra_ack = 1'b0;
        n         = 0;
        while (done == 4'b0 && n < 200) begin
            if (tx_data != exp_d) data_ok = 1'b0;
            if (ack != 4'b0) extra_ack = 1'b1;
            step();
            n++;
        end
        check("done", 32'(done), 32'(1) << exp_idx);
        check("tx_data_stable", 32'(data_ok), 32'd1);
        check("single_ack", 32'(extra_ack), 32'd0);
        check("timeout_err", 32'(timeout_err), 32'(exp_to));
    endtask

    initial begin
        int waited;
        int c;
        bit err_early;

        vecs[0]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b0, 5, 0, 8'h11};
        vecs[1]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b0, 5, 1, 8'h22};
        vecs[2]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b0, 5, 2, 8'h33};
        vecs[3]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b0, 5, 3, 8'h44};
        vecs[4]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b0, 5, 0, 8'h11};
        vecs[5]  = '{4'b0010, 32'h0000_BB00, 1'b0, 1'b0, 3, 1, 8'hBB};
        vecs[6]  = '{4'b1001, 32'hD400_00C1, 1'b0, 1'b0, 3, 3, 8'hD4};
        vecs[7]  = '{4'b1001, 32'hD400_00C1, 1'b0, 1'b0, 3, 0, 8'hC1};
        vecs[8]  = '{4'b0110, 32'h0077_6600, 1'b0, 1'b0, 2, 1, 8'h66};
        vecs[9]  = '{4'b0100, 32'h0077_6600, 1'b0, 1'b0, 2, 2, 8'h77};
        vecs[10] = '{4'b0001, 32'h0000_00A5, 1'b0, 1'b1, 6, 0, 8'hA5};

        rst      = 1'b1;
        req      = 4'b0;
        req_data = 32'h0;
        step();
        step();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;

        // Single request with exact cycle positions, grant edge = cycle 1.
        req      = 4'b0001;
        req_data = 32'h0000_00A5;
        busy_len = 20;
        step();
        check("single_ack_c1", 32'(ack), 32'h1);
        check("single_start_c1", 32'(tx_start), 32'd0);
        req = 4'b0;
        step();
        check("single_start_c2", 32'(tx_start), 32'd1);
        check("single_ack_c2", 32'(ack), 32'd0);
        c = 2;
        while (done == 4'b0 && c < 60) begin
            step();
            c++;
        end
        check("single_done_cycle", 32'(c), 32'd24);
        check("single_done_vec", 32'(done), 32'h1);
        check("single_tx_data", 32'(tx_data), 32'hA5);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            run_frame(vecs[i].req, vecs[i].data, vecs[i].hold, vecs[i].mutate, vecs[i].blen,
                      vecs[i].exp_idx, vecs[i].exp_data, 1'b0, waited);
        end

        // Busy already high when the request arrives.
        force_busy = 1'b1;
        req        = 4'b0010;
        req_data   = 32'h0000_3C00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("busy_no_ack", 32'(ack), 32'd0);
        end
        force_busy = 1'b0;
        run_frame(4'b0010, 32'h0000_3C00, 1'b0, 1'b0, 4, 1, 8'h3C, 1'b0, waited);
        check("busy_ack_latency", 32'(waited), 32'd1);

        // UART never raises busy: timeout after 16 WAIT_BUSY cycles.
        req      = 4'b0001;
        req_data = 32'h0000_00E7;
        busy_len = 0;
        step();
        check("to_ack", 32'(ack), 32'h1);
        req       = 4'b0;
        c         = 1;
        err_early = 1'b0;
        while (done == 4'b0 && c < 60) begin
            if (timeout_err) err_early = 1'b1;
            step();
            c++;
        end
        check("to_done_cycle", 32'(c), 32'd18);
        check("to_done_vec", 32'(done), 32'h1);
        check("to_not_early", 32'(err_early), 32'd0);
        check("to_err_set", 32'(timeout_err), 32'd1);
        run_frame(4'b0010, 32'h0000_5500, 1'b0, 1'b0, 5, 1, 8'h55, 1'b1, waited);

        // Reset while the UART is busy (WAIT_DONE).
        req      = 4'b0001;
        req_data = 32'h0000_0099;
        busy_len = 20;
        step();
        check("mid_ack", 32'(ack), 32'h1);
        req = 4'b0;
        repeat (6) step();
        check("mid_busy", 32'(tx_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        check("mid_rst_start", 32'(tx_start), 32'd0);
        step();
        check("mid_rst_done1", 32'(done), 32'd0);
        step();
        check("mid_rst_done2", 32'(done), 32'd0);
        rst      = 1'b0;
        req      = 4'b0100;
        req_data = 32'h00C3_0000;
        busy_len = 5;
        step();
        check("post_rst_ack", 32'(ack), 32'h4);
        check("post_rst_owner", 32'(owner), 32'd2);
        check("post_rst_tx_data", 32'(tx_data), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
